// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main control FSM.
package mips_ctrl_pkg;

  localparam int OP_W    = 6;
  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_SPARE_12  = 4'd12,
    S_SPARE_13  = 4'd13,
    S_SPARE_14  = 4'd14,
    S_SPARE_15  = 4'd15
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] ALUB_REG     = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       instr_done;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = ctrl_t'({$bits(ctrl_t){1'b0}});

  function automatic logic op_supported(input logic [OP_W-1:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_supported = 1'b1;
      default:                                       op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_out_dec.sv
// Combinational control-vector decode from the current FSM state.
// en=0 forces every control (including pulses) to zero.
module mips_ctrl_out_dec
  import mips_ctrl_pkg::*;
(
  input  state_t          state,
  input  logic            en,
  input  logic            mem_ready,
  input  logic [OP_W-1:0] opcode,
  output ctrl_t           ctrl
);

  // State decode; only fetch strobes, decode pulses and the sw completion look at inputs
  always_comb begin
    ctrl = CTRL_NONE;
    if (en) begin
      case (state)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = ALUB_FOUR;
          ctrl.alu_op    = ALU_OP_ADD;
          ctrl.pc_source = PCSRC_ALU;
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
        end
        S_DECODE: begin
          ctrl.alu_src_b = ALUB_IMM_SH2;
          ctrl.alu_op    = ALU_OP_ADD;
          if (!op_supported(opcode)) begin
            ctrl.illegal_op = 1'b1;
            ctrl.instr_done = 1'b1;
          end else begin
            ctrl.illegal_op = 1'b0;
            ctrl.instr_done = 1'b0;
          end
        end
        S_MEM_ADDR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = ALUB_IMM;
        end
        S_MEM_READ: begin
          ctrl.mem_read = 1'b1;
          ctrl.i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          ctrl.mem_write  = 1'b1;
          ctrl.i_or_d     = 1'b1;
          ctrl.instr_done = mem_ready;
        end
        S_R_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = ALUB_REG;
          ctrl.alu_op    = ALU_OP_FUNCT;
        end
        S_R_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_op        = ALU_OP_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = PCSRC_ALUOUT;
          ctrl.instr_done    = 1'b1;
        end
        S_JUMP: begin
          ctrl.pc_write   = 1'b1;
          ctrl.pc_source  = PCSRC_JUMP;
          ctrl.instr_done = 1'b1;
        end
        S_ADDI_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = ALUB_IMM;
        end
        S_ADDI_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        default: ctrl = CTRL_NONE;
      endcase
    end else begin
      ctrl = CTRL_NONE;
    end
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath: state register and
// next-state logic; control outputs come from mips_ctrl_out_dec.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic               instr_done,
  output logic [STATE_W-1:0] state_dbg
);

  state_t state_r;
  state_t state_nxt_s;
  ctrl_t  ctrl_s;

  // Next-state selection; spare encodings fall back to fetch
  always_comb begin
    state_nxt_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        if (mem_ready) begin
          state_nxt_s = S_DECODE;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt_s = S_MEM_ADDR;
          OP_RTYPE:     state_nxt_s = S_R_EXEC;
          OP_BEQ:       state_nxt_s = S_BRANCH;
          OP_J:         state_nxt_s = S_JUMP;
          OP_ADDI:      state_nxt_s = S_ADDI_EXEC;
          default:      state_nxt_s = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        if (opcode == OP_SW) begin
          state_nxt_s = S_MEM_WRITE;
        end else begin
          state_nxt_s = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        if (mem_ready) begin
          state_nxt_s = S_MEM_WB;
        end else begin
          state_nxt_s = S_MEM_READ;
        end
      end
      S_MEM_WRITE: begin
        if (mem_ready) begin
          state_nxt_s = S_FETCH;
        end else begin
          state_nxt_s = S_MEM_WRITE;
        end
      end
      S_R_EXEC:    state_nxt_s = S_R_WB;
      S_ADDI_EXEC: state_nxt_s = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: state_nxt_s = S_FETCH;
      default:     state_nxt_s = S_FETCH;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Decoder is disabled while reset is held so no strobe leaks in the reset cycle
  mips_ctrl_out_dec u_out_dec (
    .state     (state_r),
    .en        (rst_n),
    .mem_ready (mem_ready),
    .opcode    (opcode[5:0]),
    .ctrl      (ctrl_s)
  );

  assign pc_write      = ctrl_s.pc_write;
  assign pc_write_cond = ctrl_s.pc_write_cond;
  assign i_or_d        = ctrl_s.i_or_d;
  assign mem_read      = ctrl_s.mem_read;
  assign mem_write     = ctrl_s.mem_write;
  assign ir_write      = ctrl_s.ir_write;
  assign mem_to_reg    = ctrl_s.mem_to_reg;
  assign reg_dst       = ctrl_s.reg_dst;
  assign reg_write     = ctrl_s.reg_write;
  assign alu_src_a     = ctrl_s.alu_src_a;
  assign alu_src_b     = ctrl_s.alu_src_b;
  assign alu_op        = ctrl_s.alu_op;
  assign pc_source     = ctrl_s.pc_source;
  assign illegal_op    = ctrl_s.illegal_op;
  assign instr_done    = ctrl_s.instr_done;
  assign state_dbg     = rst_n ? STATE_W'(state_r) : {STATE_W{1'b0}};

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed per-cycle bench for mips_multicycle_ctrl: each cycle compares the
// packed {state_dbg, controls} vector against a hand-written expectation.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, instr_done;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_dbg;
  logic [21:0] obs;

  int tests_run = 0;
  int tests_failed = 0;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .instr_done(instr_done),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign obs = {state_dbg, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                alu_src_b, alu_op, pc_source, illegal_op, instr_done};

  function automatic logic [21:0] mk(input logic [3:0] st,
      input logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa,
      input logic [1:0] asb, aop, psrc, input logic ill, done);
    return {st, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa,
            asb, aop, psrc, ill, done};
  endfunction

  logic [21:0] v_zero, v_f_rdy, v_f_nr, v_dec, v_dec_ill, v_maddr, v_mrd, v_mwb;
  logic [21:0] v_mwr_nr, v_mwr_rdy, v_rex, v_rwb, v_br, v_j, v_aex, v_awb;

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'b000000;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      #2;
      tests_run++;
      if (obs !== v_zero) begin
        tests_failed++;
        $display("FAIL reset_hold cyc %0d: got %h expected %h", i, obs, v_zero);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    #2;
    tests_run++;
    if (obs !== v_f_rdy) begin
      tests_failed++;
      $display("FAIL reset_release: got %h expected %h", obs, v_f_rdy);
    end
    mem_ready = 1'b0;
    #1;
    tests_run++;
    if (obs !== v_f_nr) begin
      tests_failed++;
      $display("FAIL fetch_stall: got %h expected %h", obs, v_f_nr);
    end
    @(posedge clk); #1;
    #2;
    tests_run++;
    if (obs !== v_f_nr) begin
      tests_failed++;
      $display("FAIL fetch_stay: got %h expected %h", obs, v_f_nr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    logic [21:0] e [5];
    logic        r [5];
    e = '{v_f_rdy, v_dec, v_maddr, v_mrd, v_mwb};
    r = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    opcode = 6'b100011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = r[i];
      #2;
      tests_run++;
      if (obs !== e[i]) begin
        tests_failed++;
        $display("FAIL lw cyc %0d: got %h expected %h", i, obs, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_wait();
    logic [21:0] e [7];
    logic        r [7];
    e = '{v_f_rdy, v_dec, v_maddr, v_mwr_nr, v_mwr_nr, v_mwr_nr, v_mwr_rdy};
    r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    opcode = 6'b101011;
    for (int i = 0; i < 7; i++) begin
      mem_ready = r[i];
      #2;
      tests_run++;
      if (obs !== e[i]) begin
        tests_failed++;
        $display("FAIL sw_wait cyc %0d: got %h expected %h", i, obs, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] e [14];
    logic [5:0]  op [14];
    e  = '{v_f_rdy, v_dec, v_br,
           v_f_rdy, v_dec, v_j,
           v_f_rdy, v_dec, v_aex, v_awb,
           v_f_rdy, v_dec, v_rex, v_rwb};
    op = '{6'b000100, 6'b000100, 6'b000100,
           6'b000010, 6'b000010, 6'b000010,
           6'b001000, 6'b001000, 6'b001000, 6'b001000,
           6'b000000, 6'b000000, 6'b000000, 6'b000000};
    mem_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      opcode = op[i];
      #2;
      tests_run++;
      if (obs !== e[i]) begin
        tests_failed++;
        $display("FAIL back_to_back cyc %0d: got %h expected %h", i, obs, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [21:0] e [3];
    logic        r [3];
    e = '{v_f_rdy, v_dec_ill, v_f_nr};
    r = '{1'b1, 1'b1, 1'b0};
    opcode = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      mem_ready = r[i];
      #2;
      tests_run++;
      if (obs !== e[i]) begin
        tests_failed++;
        $display("FAIL illegal cyc %0d: got %h expected %h", i, obs, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mid_reset();
    logic [21:0] e [4];
    logic        r [4];
    e = '{v_f_rdy, v_dec, v_maddr, v_mrd};
    r = '{1'b1, 1'b1, 1'b1, 1'b0};
    opcode = 6'b100011;
    for (int i = 0; i < 4; i++) begin
      mem_ready = r[i];
      #2;
      tests_run++;
      if (obs !== e[i]) begin
        tests_failed++;
        $display("FAIL mid_reset_seq cyc %0d: got %h expected %h", i, obs, e[i]);
      end
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    tests_run++;
    if (obs !== v_zero) begin
      tests_failed++;
      $display("FAIL mid_reset_assert: got %h expected %h", obs, v_zero);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #2;
      tests_run++;
      if (obs !== v_f_nr) begin
        tests_failed++;
        $display("FAIL mid_reset_release cyc %0d: got %h expected %h", i, obs, v_f_nr);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'b000000;
    //           st     pcw  pcwc iord mrd  mwr  irw  m2r  rdst rw   asa  asb    aop    psrc   ill  done
    v_zero    = mk(4'd0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0);
    v_f_rdy   = mk(4'd0,  1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0);
    v_f_nr    = mk(4'd0,  1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0);
    v_dec     = mk(4'd1,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0);
    v_dec_ill = mk(4'd1,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1,1'b1);
    v_maddr   = mk(4'd2,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0);
    v_mrd     = mk(4'd3,  1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0);
    v_mwb     = mk(4'd4,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1);
    v_mwr_nr  = mk(4'd5,  1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0);
    v_mwr_rdy = mk(4'd5,  1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1);
    v_rex     = mk(4'd6,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0);
    v_rwb     = mk(4'd7,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1);
    v_br      = mk(4'd8,  1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0,1'b1);
    v_j       = mk(4'd9,  1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0,1'b1);
    v_aex     = mk(4'd10, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0);
    v_awb     = mk(4'd11, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1);

    test_reset();
    test_lw();
    test_sw_wait();
    test_back_to_back();
    test_illegal();
    test_mid_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
